// File: rtl/fifo_stream_reader.sv
// ============================================================================
//  Module   : fifo_stream_reader
//  Purpose  : Read-side drain controller for the asynchronous FIFO. Issues
//             read strobes, absorbs the FIFO's one-cycle registered read
//             latency in a 3-entry skid buffer, and presents the words as a
//             valid/ready stream at up to one word per clock.
//  Options  : FIFO_STREAM_READER_LAST_EN - when defined, frames the stream
//             into PACKET_LEN-word packets and drives Last_out.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PACKET_LEN = 16
) (
    input  logic                  Clk,
    input  logic                  Clear_in,
    input  logic [DATA_WIDTH-1:0] FifoData_in,
    input  logic                  FifoEmpty_in,
    output logic                  FifoReadEn_out,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  Valid_out,
    input  logic                  Ready_in,
    output logic                  Last_out,
    output logic [1:0]            Level_out
);

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic [1:0]            wptr_q, wptr_d;
    logic [1:0]            rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] mem_q [3];

    logic                  w_capture;
    logic                  w_pop;
    logic [2:0]            w_committed;

    // Present only for an out-of-range packet length, so a bad build shows up
    // as an extra scope in the elaborated hierarchy.
    if (PACKET_LEN < 1 || PACKET_LEN > 65535) begin : g_bad_packet_len
    end

    // Pointers step 0 -> 1 -> 2 -> 0 over the three buffer slots.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Slots already owned: held words plus the word still in flight.
    // Ready_in is deliberately left out so the strobe never depends on
    // downstream combinational paths.
    assign w_committed    = {1'b0, occ_q} + {2'b00, inflight_q};
    assign FifoReadEn_out = ~FifoEmpty_in & (w_committed < 3'd3);

    // A strobe issued on the previous edge lands in FifoData_in this cycle.
    assign w_capture = inflight_q;
    assign w_pop     = Valid_out & Ready_in;

    assign Valid_out = (occ_q != 2'd0);
    assign Data_out  = mem_q[rptr_q];
    assign Level_out = occ_q;

    // Next-state for occupancy and both ring pointers.
    always_comb begin
        occ_d  = occ_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (w_capture) begin
            wptr_d = ptr_inc(wptr_q);
        end
        if (w_pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        case ({w_capture, w_pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Control state; clear drops any in-flight word along with the FIFO.
    always_ff @(posedge Clk or posedge Clear_in) begin
        if (Clear_in) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            wptr_q     <= 2'd0;
            rptr_q     <= 2'd0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= FifoReadEn_out;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // Skid storage; cleared so Data_out reads zero out of reset.
    always_ff @(posedge Clk or posedge Clear_in) begin
        if (Clear_in) begin
            for (int i = 0; i < 3; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_capture) begin
            mem_q[wptr_q] <= FifoData_in;
        end
    end

`ifdef FIFO_STREAM_READER_LAST_EN
    localparam logic [15:0] c_LAST_IDX = 16'(PACKET_LEN - 1);

    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    // Word index within the current packet, advanced on every pop.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (w_pop) begin
            pkt_cnt_d = (pkt_cnt_q == c_LAST_IDX) ? 16'd0 : pkt_cnt_q + 16'd1;
        end
    end

    // Packet position register; restarts framing on clear.
    always_ff @(posedge Clk or posedge Clear_in) begin
        if (Clear_in) begin
            pkt_cnt_q <= 16'd0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign Last_out = Valid_out & (pkt_cnt_q == c_LAST_IDX);
`else
    assign Last_out = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// ============================================================================
//  Module   : tb_fifo_stream_reader
//  Purpose  : Directed self-checking bench for fifo_stream_reader with a
//             behavioural FIFO model (registered read, async clear).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_stream_reader;

    localparam int DW   = 8;
    localparam int PLEN = 4;

    logic          Clk;
    logic          Clear_in;
    logic [DW-1:0] FifoData_in;
    logic          FifoEmpty_in;
    logic          FifoReadEn_out;
    logic [DW-1:0] Data_out;
    logic          Valid_out;
    logic          Ready_in;
    logic          Last_out;
    logic [1:0]    Level_out;

    logic          fifo_wr;
    logic [DW-1:0] fifo_wdata;
    logic [DW-1:0] fifo_q [$];

    logic [DW-1:0] out_q  [$];
    logic          last_q [$];
    int            cyc_q  [$];
    int            cyc;

    int n_cmp;
    int n_err;

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .PACKET_LEN (PLEN)
    ) dut (
        .Clk            (Clk),
        .Clear_in       (Clear_in),
        .FifoData_in    (FifoData_in),
        .FifoEmpty_in   (FifoEmpty_in),
        .FifoReadEn_out (FifoReadEn_out),
        .Data_out       (Data_out),
        .Valid_out      (Valid_out),
        .Ready_in       (Ready_in),
        .Last_out       (Last_out),
        .Level_out      (Level_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // FIFO model: registered read data, Empty updated at the clock edge,
    // everything discarded on the shared clear net.
    always @(posedge Clk or posedge Clear_in) begin
        if (Clear_in) begin
            fifo_q.delete();
            FifoEmpty_in <= 1'b1;
            FifoData_in  <= '0;
        end else begin
            if (FifoReadEn_out && fifo_q.size() > 0) begin
                FifoData_in <= fifo_q.pop_front();
            end
            if (fifo_wr) begin
                fifo_q.push_back(fifo_wdata);
            end
            FifoEmpty_in <= (fifo_q.size() == 0);
        end
    end

    // Record every handshake; sampled mid-cycle so inputs and outputs are settled.
    always @(negedge Clk) begin
        if (Valid_out === 1'b1 && Ready_in === 1'b1) begin
            out_q.push_back(Data_out);
            last_q.push_back(Last_out);
            cyc_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_mon();
        out_q.delete();
        last_q.delete();
        cyc_q.delete();
    endtask

    task automatic fifo_write(input logic [DW-1:0] d);
        fifo_wr    = 1'b1;
        fifo_wdata = d;
        tick();
        fifo_wr    = 1'b0;
    endtask

    task automatic test_reset();
        Clear_in = 1'b1;
        Ready_in = 1'b0;
        fifo_wr  = 1'b0;
        tick();
        tick();
        n_cmp++; if (FifoReadEn_out !== 1'b0) begin n_err++; $display("FAIL reset_rden: got %b expected 0", FifoReadEn_out); end
        n_cmp++; if (Valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", Valid_out); end
        n_cmp++; if (Data_out !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", Data_out); end
        n_cmp++; if (Last_out !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b expected 0", Last_out); end
        n_cmp++; if (Level_out !== 2'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", Level_out); end
        Clear_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (FifoReadEn_out !== 1'b0 || Valid_out !== 1'b0 || Level_out !== 2'd0) begin
                n_err++;
                $display("FAIL idle_cycle%0d: got rden=%b valid=%b level=%0d expected 0/0/0",
                         i, FifoReadEn_out, Valid_out, Level_out);
            end
        end
    endtask

    task automatic test_stream_basic();
        logic [DW-1:0] exp_w [3];
        int            s;
        exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33;
        clear_mon();
        Ready_in = 1'b1;
        s = cyc;
        for (int i = 0; i < 3; i++) fifo_write(exp_w[i]);
        repeat (10) tick();
        n_cmp++;
        if (out_q.size() != 3) begin
            n_err++; $display("FAIL basic_count: got %0d expected 3", out_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (out_q[i] !== exp_w[i]) begin n_err++; $display("FAIL basic_word%0d: got %h expected %h", i, out_q[i], exp_w[i]); end
            end
            n_cmp++; if (cyc_q[0] != s + 3) begin n_err++; $display("FAIL basic_latency: got %0d expected %0d", cyc_q[0] - s, 3); end
            n_cmp++;
            if (cyc_q[1] != cyc_q[0] + 1 || cyc_q[2] != cyc_q[1] + 1) begin
                n_err++; $display("FAIL basic_consecutive: got cycles %0d,%0d,%0d expected back-to-back", cyc_q[0], cyc_q[1], cyc_q[2]);
            end
        end
        n_cmp++; if (Valid_out !== 1'b0) begin n_err++; $display("FAIL basic_drain_valid: got %b expected 0", Valid_out); end
        n_cmp++; if (Level_out !== 2'd0) begin n_err++; $display("FAIL basic_drain_level: got %0d expected 0", Level_out); end
    endtask

    task automatic test_backpressure();
        clear_mon();
        Ready_in = 1'b0;
        for (int i = 0; i < 10; i++) fifo_write(8'(8'h40 + i));
        repeat (4) tick();
        n_cmp++; if (Level_out !== 2'd3) begin n_err++; $display("FAIL bp_level: got %0d expected 3", Level_out); end
        n_cmp++; if (FifoReadEn_out !== 1'b0) begin n_err++; $display("FAIL bp_rden: got %b expected 0", FifoReadEn_out); end
        n_cmp++; if (Valid_out !== 1'b1 || Data_out !== 8'h40) begin n_err++; $display("FAIL bp_head: got valid=%b data=%h expected 1/40", Valid_out, Data_out); end
        n_cmp++; if (fifo_q.size() != 7) begin n_err++; $display("FAIL bp_fifo_left: got %0d expected 7", fifo_q.size()); end
        n_cmp++; if (out_q.size() != 0) begin n_err++; $display("FAIL bp_no_pop: got %0d expected 0", out_q.size()); end
        Ready_in = 1'b1;
        repeat (16) tick();
        n_cmp++;
        if (out_q.size() != 10) begin
            n_err++; $display("FAIL bp_count: got %0d expected 10", out_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_cmp++;
                if (out_q[i] !== 8'(8'h40 + i)) begin n_err++; $display("FAIL bp_word%0d: got %h expected %h", i, out_q[i], 8'(8'h40 + i)); end
            end
            for (int i = 1; i < 10; i++) begin
                n_cmp++;
                if (cyc_q[i] != cyc_q[i-1] + 1) begin n_err++; $display("FAIL bp_gap%0d: got %0d expected %0d", i, cyc_q[i], cyc_q[i-1] + 1); end
            end
        end
        Ready_in = 1'b0;
    endtask

    task automatic test_toggle_ready();
        logic          hold;
        logic [DW-1:0] held;
        int            widx;
        clear_mon();
        hold = 1'b0;
        held = '0;
        widx = 0;
        for (int c = 0; c < 120; c++) begin
            Ready_in = (c % 2 == 0);
            if (widx < 32) begin
                fifo_wr    = 1'b1;
                fifo_wdata = 8'(8'h80 + widx);
                widx++;
            end else begin
                fifo_wr = 1'b0;
            end
            @(negedge Clk);
            if (hold) begin
                n_cmp++;
                if (Valid_out !== 1'b1 || Data_out !== held) begin
                    n_err++; $display("FAIL toggle_stable_c%0d: got valid=%b data=%h expected 1/%h", c, Valid_out, Data_out, held);
                end
            end
            hold = Valid_out & ~Ready_in;
            held = Data_out;
            @(posedge Clk);
            #1;
        end
        fifo_wr  = 1'b0;
        Ready_in = 1'b0;
        n_cmp++;
        if (out_q.size() != 32) begin
            n_err++; $display("FAIL toggle_count: got %0d expected 32", out_q.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                n_cmp++;
                if (out_q[i] !== 8'(8'h80 + i)) begin n_err++; $display("FAIL toggle_word%0d: got %h expected %h", i, out_q[i], 8'(8'h80 + i)); end
            end
        end
    endtask

    task automatic test_clear_inflight();
        logic found;
        Ready_in = 1'b0;
        for (int i = 0; i < 6; i++) fifo_write(8'(8'h60 + i));
        repeat (3) tick();
        Ready_in = 1'b1;
        tick();
        Ready_in = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (Level_out == 2'd2 && FifoReadEn_out == 1'b0 && FifoEmpty_in == 1'b0) begin
                found = 1'b1;
                break;
            end
            @(posedge Clk);
            #1;
        end
        n_cmp++;
        if (!found) begin
            n_err++; $display("FAIL clr_setup: got found=0 expected 1 (occ=2 with read in flight)");
        end else begin
            Clear_in = 1'b1;
            #1;
            n_cmp++; if (Valid_out !== 1'b0) begin n_err++; $display("FAIL clr_valid: got %b expected 0", Valid_out); end
            n_cmp++; if (Level_out !== 2'd0) begin n_err++; $display("FAIL clr_level: got %0d expected 0", Level_out); end
            n_cmp++; if (Data_out !== 8'h00) begin n_err++; $display("FAIL clr_data: got %h expected 00", Data_out); end
            @(posedge Clk);
            #1;
            Clear_in = 1'b0;
        end
        clear_mon();
        Ready_in = 1'b1;
        fifo_write(8'hA5);
        repeat (8) tick();
        n_cmp++;
        if (out_q.size() != 1) begin
            n_err++; $display("FAIL clr_after_count: got %0d expected 1", out_q.size());
        end else begin
            n_cmp++; if (out_q[0] !== 8'hA5) begin n_err++; $display("FAIL clr_after_word: got %h expected a5", out_q[0]); end
        end
        Ready_in = 1'b0;
    endtask

    task automatic test_packet_last();
        logic exp_l;
        // Restart framing from a known packet position.
        Clear_in = 1'b1;
        tick();
        Clear_in = 1'b0;
        clear_mon();
        Ready_in = 1'b1;
        for (int i = 0; i < 12; i++) fifo_write(8'(8'hC0 + i));
        repeat (8) tick();
        n_cmp++;
        if (out_q.size() != 12) begin
            n_err++; $display("FAIL pkt_count: got %0d expected 12", out_q.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
`ifdef FIFO_STREAM_READER_LAST_EN
                exp_l = ((i % PLEN) == PLEN - 1);
`else
                exp_l = 1'b0;
`endif
                n_cmp++;
                if (last_q[i] !== exp_l || out_q[i] !== 8'(8'hC0 + i)) begin
                    n_err++; $display("FAIL pkt_word%0d: got data=%h last=%b expected %h/%b", i, out_q[i], last_q[i], 8'(8'hC0 + i), exp_l);
                end
            end
        end
        // Two words into a packet, then clear: framing restarts from word 1.
        for (int i = 0; i < 2; i++) fifo_write(8'(8'hD0 + i));
        repeat (6) tick();
        Clear_in = 1'b1;
        tick();
        Clear_in = 1'b0;
        clear_mon();
        for (int i = 0; i < 6; i++) fifo_write(8'(8'hE0 + i));
        repeat (10) tick();
        n_cmp++;
        if (out_q.size() != 6) begin
            n_err++; $display("FAIL pkt_clr_count: got %0d expected 6", out_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
`ifdef FIFO_STREAM_READER_LAST_EN
                exp_l = (i == 3);
`else
                exp_l = 1'b0;
`endif
                n_cmp++;
                if (last_q[i] !== exp_l) begin n_err++; $display("FAIL pkt_clr_last%0d: got %b expected %b", i, last_q[i], exp_l); end
            end
        end
        n_cmp++; if (Last_out !== 1'b0) begin n_err++; $display("FAIL pkt_idle_last: got %b expected 0", Last_out); end
        Ready_in = 1'b0;
    endtask

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        cyc          = 0;
        Clear_in     = 1'b1;
        Ready_in     = 1'b0;
        fifo_wr      = 1'b0;
        fifo_wdata   = '0;
        FifoEmpty_in = 1'b1;
        FifoData_in  = '0;
        test_reset();
        test_stream_basic();
        test_backpressure();
        test_toggle_ready();
        test_clear_inflight();
        test_packet_last();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain controller for the asynchronous FIFO. Runs entirely in the FIFO's read clock domain, issues read strobes to the FIFO read port, absorbs the FIFO's one-cycle registered read latency in a 3-entry skid buffer, and presents the words as a valid/ready stream to downstream logic at up to one word per clock. Optionally frames the stream into fixed-length packets.

## Interface
- DATA_WIDTH, 8: word width; must match the FIFO's DATA_WIDTH.
- PACKET_LEN, 16: words per packet when framing is compiled in; legal range 1..65535.

- Clk  input  1  read-domain clock; same net as the FIFO's RClk.
- Clear_in  input  1  asynchronous, active-high reset; same net as the FIFO's Clear_in.
- FifoData_in  input  DATA_WIDTH  FIFO Data_out.
- FifoEmpty_in  input  1  FIFO Empty_out.
- FifoReadEn_out  output  1  to FIFO ReadEn_in.
- Data_out  output  DATA_WIDTH  stream data, head of the skid buffer.
- Valid_out  output  1  stream valid.
- Ready_in  input  1  stream ready from downstream.
- Last_out  output  1  marks the final word of a packet; qualified by Valid_out.
- Level_out  output  2  skid-buffer occupancy, 0..3.

## Operation
- State:
  - occupancy `occ`, 0..3;
  - in-flight flag `inflight`, set when a read was issued on the previous edge;
  - 3-entry circular buffer with 2-bit read and write pointers, each wrapping 2→0;
  - packet word counter `pkt_cnt`, 16 bits.
- Read issue: FifoReadEn_out = ~FifoEmpty_in & ((occ + inflight) < 3). Combinational from registered state and FifoEmpty_in only; never from Ready_in.
- Read strobes are issued only while the FIFO is non-empty, so the FIFO's zero-on-empty-read path is never exercised.
- Every clock edge: `inflight` takes the value of FifoReadEn_out sampled at that edge.
- Capture: on an edge where `inflight` = 1, FifoData_in is written at the write pointer and the write pointer advances.
- Pop: on an edge where Valid_out & Ready_in, the read pointer advances.
- Occupancy update: `occ` next = `occ` + capture − pop. Capture and pop on the same edge leave `occ` unchanged.
- Capacity: the issue rule guarantees `occ` never exceeds 3. Overflow is impossible by construction; a capture while `occ` = 3 and no pop is a verification failure.
- Outputs: Valid_out = (`occ` != 0). Data_out = buffer[read pointer]. Level_out = `occ`.
- Stream rule: once Valid_out is high, Data_out is stable until popped.
- Clear_in asserted: `occ`, `inflight`, pointers and `pkt_cnt` go to 0 immediately. The word of a discarded in-flight read is dropped; the FIFO is cleared on the same net, so no data is lost relative to the FIFO's state.

## Timing
- Reset values: FifoReadEn_out = 0 (the FIFO presets Empty during clear), Valid_out = 0, Data_out = 0 (buffer cleared), Last_out = 0, Level_out = 0.
- Latency: read strobe sampled at edge E → FIFO updates FifoData_in at E → captured at E+1 → Valid_out high after E+1. First word after FIFO goes non-empty appears 2 edges after the first strobe.
- Throughput: with Ready_in held high, steady state is `occ` = 1 and `inflight` = 1, sustaining one word per clock with no bubbles.
- Back-pressure: Ready_in low with `occ` = 2 and `inflight` = 1 blocks new reads. When Ready_in returns high, the head word pops on the first edge.
- FifoEmpty_in rising (asynchronous preset) mid-cycle suppresses the strobe immediately; words already in flight are still captured.

## Configuration
- FIFO_STREAM_READER_LAST_EN defined:
  - `pkt_cnt` increments on each pop and wraps to 0 after the pop where `pkt_cnt` = PACKET_LEN−1;
  - Last_out = Valid_out & (`pkt_cnt` == PACKET_LEN−1);
  - PACKET_LEN = 1 makes every word Last.
- Not defined: `pkt_cnt` is not built; Last_out is tied 0. PACKET_LEN is ignored.

## Test plan
- Reset, FIFO empty → FifoReadEn_out = 0, Valid_out = 0, Level_out = 0 for 20 cycles.
- Write 0x11, 0x22, 0x33 to the FIFO, Ready_in = 1 → stream emits 0x11, 0x22, 0x33 on 3 consecutive cycles. Valid_out drops when the FIFO empties. No 0x00 word ever appears.
- Write 10 words, Ready_in = 0 → Level_out settles at 3, FifoReadEn_out = 0, FIFO holds 7. Then set Ready_in = 1 → all 10 words emitted in order, one per cycle after the first.
- Ready_in toggling 1010… over 32 words → every word delivered exactly once, in order, and Data_out is stable whenever Valid_out & ~Ready_in.
- Assert Clear_in for 1 cycle while `occ` = 2 and `inflight` = 1 → Valid_out = 0 and Level_out = 0 immediately. After a subsequent write of 0xA5, exactly 0xA5 is emitted.
- FIFO_STREAM_READER_LAST_EN, PACKET_LEN = 4, 12 words streamed → Last_out high on words 4, 8 and 12 only. After a mid-packet Clear_in, the next Last_out falls on the 4th word following the clear.
